// File: rtl/nexys_starship_spawn_sched_pkg.sv
// Shared types and helpers for the starship monster spawn scheduler:
// scheduler state encoding, station index constants and a 4-bit popcount.
package nexys_starship_spawn_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_COUNT = 2'b01,
      S_ARB   = 2'b10
   } sched_state_e;

   localparam logic [1:0] ST_RIGHT = 2'd0;
   localparam logic [1:0] ST_LEFT  = 2'd1;
   localparam logic [1:0] ST_BTM   = 2'd2;
   localparam logic [1:0] ST_TOP   = 2'd3;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/nexys_starship_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo 4.
module nexys_starship_rr_pick
   import nexys_starship_spawn_sched_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       any
);

   // scan the four slots starting at ptr and keep the first hit
   always_comb begin
      logic [1:0] idx;
      logic       hit;
      gnt_idx = 2'd0;
      any     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx     = ptr + 2'(i);
         hit     = req[idx] & ~any;
         gnt_idx = hit ? idx : gnt_idx;
         any     = any | req[idx];
      end
      gnt = any ? (4'b0001 << gnt_idx) : 4'b0000;
   end

endmodule

// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: periodic arbitration between the four stations,
// with an occupancy cap and an interval that shrinks on every grant.
module nexys_starship_spawn_sched
   import nexys_starship_spawn_sched_pkg::*;
#(
   parameter int unsigned CNT_W      = 27,
   parameter int unsigned SPAWN_INIT = 50_000_000,
   parameter int unsigned SPAWN_STEP = 2_000_000,
   parameter int unsigned SPAWN_MIN  = 10_000_000,
   parameter int unsigned MAX_ACTIVE = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             play_flag,
   input  logic             game_over,
   input  logic [3:0]       rand_req,
   input  logic [3:0]       busy,
   output logic [3:0]       spawn,
   output logic [2:0]       active_cnt,
   output logic [1:0]       sched_state,
   output logic [CNT_W-1:0] cur_interval
);

   localparam logic [CNT_W-1:0] INIT_V  = CNT_W'(SPAWN_INIT);
   localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(SPAWN_MIN);
   localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(SPAWN_STEP);
   localparam logic [CNT_W-1:0] FLOOR_V = CNT_W'(SPAWN_MIN + SPAWN_STEP);
   localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] interval_q, interval_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       spawn_q, spawn_d;
   logic [2:0]       active_cnt_q, active_cnt_d;

   logic             run_s;
   logic [2:0]       busy_cnt_s;
   logic [3:0]       pick_gnt_s;
   logic [1:0]       pick_idx_s;
   logic             pick_any_s;
   logic             grant_s;
   logic [CNT_W-1:0] shrunk_s;

   assign run_s      = play_flag & ~game_over;
   assign busy_cnt_s = popcount4(busy);

   nexys_starship_rr_pick u_pick (
      .req     (rand_req & ~busy),
      .ptr     (ptr_q),
      .gnt     (pick_gnt_s),
      .gnt_idx (pick_idx_s),
      .any     (pick_any_s)
   );

   assign grant_s  = run_s & pick_any_s & (busy_cnt_s < 3'(MAX_ACTIVE));
   // compare before subtracting so the interval can never wrap below the floor
   assign shrunk_s = (interval_q < FLOOR_V) ? MIN_V : (interval_q - STEP_V);

   // next-state, counter, interval and pointer logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      interval_d   = interval_q;
      ptr_d        = ptr_q;
      spawn_d      = 4'b0000;
      active_cnt_d = busy_cnt_s;
      case (state_q)
         S_IDLE: begin
            if (run_s) begin
               interval_d = INIT_V;
               cnt_d      = INIT_V - ONE_V;
               state_d    = S_COUNT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COUNT: begin
            if (!run_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = S_ARB;
            end else begin
               cnt_d = cnt_q - ONE_V;
            end
         end
         S_ARB: begin
            if (grant_s) begin
               spawn_d    = pick_gnt_s;
               ptr_d      = pick_idx_s + 2'd1;
               interval_d = shrunk_s;
            end else begin
               interval_d = interval_q;
            end
            if (run_s) begin
               cnt_d   = interval_d - ONE_V;
               state_d = S_COUNT;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         interval_q   <= INIT_V;
         ptr_q        <= 2'd0;
         spawn_q      <= 4'b0000;
         active_cnt_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         interval_q   <= interval_d;
         ptr_q        <= ptr_d;
         spawn_q      <= spawn_d;
         active_cnt_q <= active_cnt_d;
      end
   end

   assign spawn        = spawn_q;
   assign active_cnt   = active_cnt_q;
   assign sched_state  = state_q;
   assign cur_interval = interval_q;

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Self-checking bench: directed test-plan scenarios plus random traffic,
// compared every cycle against an event-time reference model.
module tb_nexys_starship_spawn_sched;

   localparam int CNT_W = 8;
   localparam int INIT  = 8;
   localparam int STEP  = 2;
   localparam int MIN   = 4;
   localparam int MAXA  = 2;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             play_flag;
   logic             game_over;
   logic [3:0]       rand_req;
   logic [3:0]       busy;
   logic [3:0]       spawn;
   logic [2:0]       active_cnt;
   logic [1:0]       sched_state;
   logic [CNT_W-1:0] cur_interval;

   int checks = 0;
   int errors = 0;

   // reference model: absolute edge number of the next arbitration
   int         e_n = 0;
   bit         m_active;
   int         m_arb_edge;
   int         m_interval;
   int         m_ptr;
   logic [3:0] exp_spawn;
   logic [1:0] exp_state;
   logic [2:0] exp_cnt;

   nexys_starship_spawn_sched #(
      .CNT_W(CNT_W), .SPAWN_INIT(INIT), .SPAWN_STEP(STEP),
      .SPAWN_MIN(MIN), .MAX_ACTIVE(MAXA)
   ) dut (
      .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
      .rand_req(rand_req), .busy(busy), .spawn(spawn), .active_cnt(active_cnt),
      .sched_state(sched_state), .cur_interval(cur_interval)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active   = 1'b0;
      m_interval = INIT;
      m_ptr      = 0;
      exp_spawn  = 4'b0000;
      exp_state  = 2'b00;
      exp_cnt    = 3'd0;
   endtask

   task automatic model_edge();
      logic [3:0] elig;
      int         w;
      e_n++;
      exp_spawn = 4'b0000;
      exp_cnt   = 3'($countones(busy));
      if (!(play_flag && !game_over)) begin
         m_active  = 1'b0;
         exp_state = 2'b00;
      end else if (!m_active) begin
         m_active   = 1'b1;
         m_interval = INIT;
         m_arb_edge = e_n + INIT + 1;
         exp_state  = 2'b01;
      end else if (e_n == m_arb_edge) begin
         elig = rand_req & ~busy;
         w    = -1;
         for (int k = 0; k < 4; k++) begin
            if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
         end
         if ($countones(busy) < MAXA && w >= 0) begin
            exp_spawn  = 4'b0001 << w;
            m_ptr      = (w + 1) % 4;
            m_interval = (m_interval - STEP < MIN) ? MIN : m_interval - STEP;
         end
         m_arb_edge = e_n + m_interval + 1;
         exp_state  = 2'b01;
      end else begin
         exp_state = (e_n == m_arb_edge - 1) ? 2'b10 : 2'b01;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".spawn"}, 32'(spawn), 32'(exp_spawn));
      check({tag, ".state"}, 32'(sched_state), 32'(exp_state));
      check({tag, ".active_cnt"}, 32'(active_cnt), 32'(exp_cnt));
      check({tag, ".interval"}, 32'(cur_interval), 32'(m_interval));
   endtask

   task automatic cycle(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic run_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   int         s1_t[$];
   logic [3:0] s1_v[$];
   int         s1_exp_t[5];
   logic [3:0] s1_exp_v[5];
   int         s5_hit;

   initial begin
      s1_exp_t = '{10, 17, 22, 27, 32};
      s1_exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      Reset = 1'b1; play_flag = 1'b0; game_over = 1'b0;
      rand_req = 4'b0000; busy = 4'b0000;
      #2;
      model_reset();
      check_all("reset");
      #10 Reset = 1'b0;

      // 1: all stations requesting, none busy
      busy = 4'b0000; rand_req = 4'b1111; play_flag = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         cycle("s1");
         if (spawn != 4'b0000) begin
            s1_t.push_back(k);
            s1_v.push_back(spawn);
         end
      end
      check("s1.n_spawns", 32'(s1_t.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("s1.spawn_cycle", 32'((i < s1_t.size()) ? s1_t[i] : -1), 32'(s1_exp_t[i]));
         check("s1.spawn_value", 32'((i < s1_v.size()) ? s1_v[i] : 4'hx), 32'(s1_exp_v[i]));
      end

      // 2: cap reached, no grants
      play_flag = 1'b0; cycle("s2_stop");
      busy = 4'b0011; rand_req = 4'b1111; play_flag = 1'b1;
      run_cycles("s2", 30);
      check("s2.active_cnt", 32'(active_cnt), 32'd2);

      // 3: single requester moves the pointer past it
      play_flag = 1'b0; cycle("s3_stop");
      busy = 4'b0000; rand_req = 4'b0100; play_flag = 1'b1;
      run_cycles("s3a", 10);
      rand_req = 4'b1111;
      run_cycles("s3b", 9);

      // 4: every requester busy, then freed
      play_flag = 1'b0; cycle("s4_stop");
      busy = 4'b1011; rand_req = 4'b1011; play_flag = 1'b1;
      run_cycles("s4a", 12);
      busy = 4'b0000;
      run_cycles("s4b", 12);

      // 5: game over exactly while in ARB
      play_flag = 1'b0; cycle("s5_stop");
      busy = 4'b0000; rand_req = 4'b1111; play_flag = 1'b1;
      s5_hit = 0;
      for (int i = 0; i < 20 && s5_hit == 0; i++) begin
         cycle("s5a");
         if (sched_state == 2'b10) s5_hit = 1;
      end
      check("s5.reached_arb", 32'(s5_hit), 32'd1);
      game_over = 1'b1;
      cycle("s5b");
      check("s5.no_spawn", 32'(spawn), 32'd0);
      check("s5.idle", 32'(sched_state), 32'd0);
      game_over = 1'b0;
      run_cycles("s5c", 12);

      // 6: asynchronous reset between edges, mid-count
      run_cycles("s6a", 3);
      #3 Reset = 1'b1;
      #1;
      model_reset();
      check_all("s6_reset");
      check("s6.interval", 32'(cur_interval), 32'd8);
      #2 Reset = 1'b0;
      run_cycles("s6b", 12);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rand_req  = 4'($urandom);
         busy      = 4'($urandom) & 4'($urandom);
         play_flag = ($urandom_range(0, 99) != 0);
         game_over = ($urandom_range(0, 199) == 0);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
